crank_wheel_gen: RTL and testbench
==================================

Name: crank_wheel_gen

Overview:
- Synthesizable crank-wheel signal generator producing a 60-2 style toothed-wheel waveform.
- Drives the capture input of the angle-generator receiver path. Used for bench stimulus and in-system self-test loopback.
- Emits one pulse per tooth slot and suppresses the output during the missing-tooth gap.
- Also reports its slot index and a once-per-revolution marker, so the receiver's gap detection and tooth count can be checked against it.

Parameters:
- PERIOD_WIDTH, 24, width of the tooth-period input in clk cycles.
- TCNT_WIDTH, 8, width of the tooth/slot index.
- TEETH, 60, total slots per revolution, including missing ones.
- MISSING, 2, number of missing slots at the end of the revolution (slots TEETH-MISSING..TEETH-1).
- MIN_PERIOD, 4, smallest period honoured; smaller requests are clamped up to it.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- ena  input  1  run request; level-sensitive.
- period  input  PERIOD_WIDTH  slot length in clk cycles.
- tooth_out  output  1  generated wheel signal.
- tooth_num  output  TCNT_WIDTH  index of the current slot, 0..TEETH-1.
- rev_pulse  output  1  one-cycle strobe at the first cycle of slot 0.
- in_gap  output  1  high while the current slot is a missing slot.
- busy  output  1  high while in RUN.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; period shadow register = MIN_PERIOD; slot counter and cycle counter = 0.
- States:
  - IDLE -> RUN on the first clk edge with ena=1. Slot 0 begins on the following cycle.
  - RUN -> IDLE at the end of a slot (cycle counter = shadow-1) when ena=0. Slots are never truncated.
- Slot start:
  - period is sampled into the shadow register; shadow = max(period, MIN_PERIOD).
  - A period change mid-slot takes effect at the next slot boundary only.
- Within a slot: cycle counter runs 0..shadow-1.
  - tooth_out=1 for cycles 0..(shadow>>1)-1 and 0 for the rest.
  - For odd shadow, the low phase gets the extra cycle.
- Missing slots: tooth_out=0 for the whole slot; in_gap=1 for the whole slot.
- tooth_num:
  - Increments at each slot boundary.
  - Wraps from TEETH-1 to 0 at the boundary; rev_pulse=1 in that first cycle.
- Output latency: all outputs are registered and change in the same cycle as the slot/cycle counter update.
  - The rising edge of tooth_out coincides with the first cycle of the slot.
- ena=0 while in a missing slot: the gap slot completes, then IDLE; tooth_out stays 0.
- ena re-asserted in the same cycle RUN would exit: stay in RUN and continue with the next slot.
- After a stop/restart, the generator always resumes at slot 0, not mid-revolution.
- Reset mid-slot forces tooth_out=0 immediately (asynchronous), with no glitch to 1.
- Counter widths: the cycle counter is PERIOD_WIDTH bits, so no overflow is possible since shadow ≤ 2^PERIOD_WIDTH-1.
- Elaboration-time checks: MISSING < TEETH and TEETH ≤ 2^TCNT_WIDTH.

Decomposition:
- Shared package hwag_pkg holds:
  - the state enum (IDLE, RUN);
  - the default wheel constants TEETH=60, MISSING=2, matching the receiver's top compare value of 57;
  - MIN_PERIOD.
- One sub-module, slot_timer. It contains the shadow-period register, the cycle counter, and the high/low phase compare. It provides an end-of-slot strobe and a phase_high flag.
- crank_wheel_gen itself holds the FSM, the slot index, and the gap/revolution decode.

Test Plan:
- Basic wheel: period=8, ena held at 1.
  - Required: tooth_out high 4 cycles, low 4 cycles for slots 0..57.
  - Slots 58..59: low for 16 cycles with in_gap=1.
  - rev_pulse every 480 cycles; tooth_num sequence 0..59,0.
- Mid-slot period change: period changes 8->12 at cycle 3 of slot 5.
  - Required: slot 5 still 8 cycles; slot 6 high 6, low 6.
- Clamp: period=2.
  - Required: slots 4 cycles long (2 high/2 low); period=5 gives 2 high/3 low.
- Stop/restart: ena=0 during slot 10 cycle 1 (period=8).
  - Required: slot 10 completes its 8 cycles, then busy=0, tooth_out=0.
  - Re-asserting ena restarts at tooth_num=0 with rev_pulse.
- Async reset: rst=0 asynchronously mid-high-phase.
  - Required: tooth_out, busy and tooth_num all 0 before the next clk edge; after release and ena=1, normal start from slot 0.
- Loopback: output fed to the receiver path with period=1000.
  - Required: the receiver flags a gap once per 60 slots, and its tooth count aligns with tooth_num.

Source files
------------

// File: rtl/hwag_pkg.sv
// Shared types and default wheel geometry for the angle-generator stimulus/receiver pair.
package hwag_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int WHEEL_TEETH      = 60;
  localparam int WHEEL_MISSING    = 2;
  // Receiver compares against the last real tooth index (57 for a 60-2 wheel).
  localparam int RX_TOP_CMP       = WHEEL_TEETH - WHEEL_MISSING - 1;
  localparam int WHEEL_MIN_PERIOD = 4;

endpackage

// File: rtl/slot_timer.sv
// Times one wheel slot: latches the clamped period at slot start, counts cycles,
// and reports end-of-slot plus the next-cycle high/low phase.
module slot_timer
  import hwag_pkg::*;
#(
  parameter int PERIOD_WIDTH = 24,
  parameter int MIN_PERIOD   = WHEEL_MIN_PERIOD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic                    adv_i,
  input  logic                    clr_i,
  input  logic [PERIOD_WIDTH-1:0] period_i,
  output logic                    eos_o,
  output logic                    phase_high_o
);

  localparam logic [PERIOD_WIDTH-1:0] MinP = PERIOD_WIDTH'(MIN_PERIOD);

  logic [PERIOD_WIDTH-1:0] shadow_q, shadow_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      shadow_d = (period_i < MinP) ? MinP : period_i;
      cnt_d    = '0;
    end else if (clr_i) begin
      shadow_d = MinP;
      cnt_d    = '0;
    end else if (adv_i) begin
      cnt_d = cnt_q + PERIOD_WIDTH'(1);
    end
  end

  assign eos_o        = (cnt_q == shadow_q - PERIOD_WIDTH'(1));
  // Evaluated on next-state values so the caller can register tooth_out in step with the counter.
  assign phase_high_o = (cnt_d < (shadow_d >> 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q <= MinP;
      cnt_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/crank_wheel_gen.sv
// 60-2 style crank-wheel generator: one pulse per slot, silent missing-tooth gap,
// plus slot index, gap flag and once-per-revolution strobe for receiver cross-checks.
module crank_wheel_gen
  import hwag_pkg::*;
#(
  parameter int PERIOD_WIDTH = 24,
  parameter int TCNT_WIDTH   = 8,
  parameter int TEETH        = WHEEL_TEETH,
  parameter int MISSING      = WHEEL_MISSING,
  parameter int MIN_PERIOD   = WHEEL_MIN_PERIOD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [PERIOD_WIDTH-1:0] period,
  output logic                    tooth_out,
  output logic [TCNT_WIDTH-1:0]   tooth_num,
  output logic                    rev_pulse,
  output logic                    in_gap,
  output logic                    busy
);

  if (!(MISSING < TEETH)) begin : g_chk_missing
    $error("crank_wheel_gen: MISSING must be smaller than TEETH");
  end
  if (TEETH > (2 ** TCNT_WIDTH)) begin : g_chk_teeth
    $error("crank_wheel_gen: TEETH does not fit in TCNT_WIDTH");
  end

  localparam logic [TCNT_WIDTH-1:0] LastSlot = TCNT_WIDTH'(TEETH - 1);
  localparam logic [TCNT_WIDTH-1:0] GapFirst = TCNT_WIDTH'(TEETH - MISSING);

  state_e                state_q, state_d;
  logic [TCNT_WIDTH-1:0] num_q, num_d;
  logic                  tooth_q, tooth_d;
  logic                  rev_q, rev_d;
  logic                  gap_q, gap_d;
  logic                  load, adv, clr, slot_start;
  logic                  eos, phase_high;

  slot_timer #(
    .PERIOD_WIDTH (PERIOD_WIDTH),
    .MIN_PERIOD   (MIN_PERIOD)
  ) u_slot_timer (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load),
    .adv_i        (adv),
    .clr_i        (clr),
    .period_i     (period),
    .eos_o        (eos),
    .phase_high_o (phase_high)
  );

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    load       = 1'b0;
    adv        = 1'b0;
    clr        = 1'b0;
    slot_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (ena) begin
          state_d    = RUN;
          load       = 1'b1;
          slot_start = 1'b1;
          num_d      = '0;
        end
      end
      RUN: begin
        if (!eos) begin
          adv = 1'b1;
        end else if (ena) begin
          load       = 1'b1;
          slot_start = 1'b1;
          num_d      = (num_q == LastSlot) ? '0 : num_q + TCNT_WIDTH'(1);
        end else begin
          // Slots are never cut short; a stop always lands on a slot boundary and rewinds to slot 0.
          clr     = 1'b1;
          state_d = IDLE;
          num_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    gap_d   = (state_d == RUN) && (num_d >= GapFirst);
    rev_d   = slot_start && (num_d == '0);
    tooth_d = (state_d == RUN) && phase_high && !gap_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      tooth_q <= 1'b0;
      rev_q   <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      tooth_q <= tooth_d;
      rev_q   <= rev_d;
      gap_q   <= gap_d;
    end
  end

  assign tooth_out = tooth_q;
  assign tooth_num = num_q;
  assign rev_pulse = rev_q;
  assign in_gap    = gap_q;
  assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_crank_wheel_gen.sv
// Directed bench for crank_wheel_gen: vector table plus wheel, period-change, gap-stop and reset sequences.
module tb_crank_wheel_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [23:0] period;
  logic        tooth_out;
  logic [7:0]  tooth_num;
  logic        rev_pulse;
  logic        in_gap;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  crank_wheel_gen dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .period    (period),
    .tooth_out (tooth_out),
    .tooth_num (tooth_num),
    .rev_pulse (rev_pulse),
    .in_gap    (in_gap),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ena;
    logic [23:0] per;
    logic        t;
    logic [7:0]  num;
    logic        rev;
    logic        gap;
    logic        bsy;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] pk(input logic t, input logic [7:0] num, input logic rev,
                                     input logic gap, input logic bsy);
    return {20'd0, t, num, rev, gap, bsy};
  endfunction

  function automatic logic [31:0] outs();
    return pk(tooth_out, tooth_num, rev_pulse, in_gap, busy);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic add(input int e, input int p, input int t, input int n, input int r,
                     input int g, input int b);
    vec_t v;
    v.ena = e[0];
    v.per = 24'(p);
    v.t   = t[0];
    v.num = 8'(n);
    v.rev = r[0];
    v.gap = g[0];
    v.bsy = b[0];
    tbl.push_back(v);
  endtask

  initial begin
    int s, c, last_rev, last_rise, last_iv, rx_cnt, gaps, revs;
    logic prev_t;
    logic [31:0] exp;

    rst    = 1'b0;
    ena    = 1'b0;
    period = 24'd8;
    #2;
    chk("reset_outputs", outs(), pk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0));
    tick();
    tick();
    rst = 1'b1;

    // ena, period -> tooth_out, tooth_num, rev_pulse, in_gap, busy (state after the next edge)
    add(0, 2, 0, 0, 0, 0, 0);  // idle stays idle
    add(1, 2, 1, 0, 1, 0, 1);  // start: period 2 clamped to 4
    add(1, 2, 1, 0, 0, 0, 1);
    add(1, 2, 0, 0, 0, 0, 1);
    add(1, 5, 0, 0, 0, 0, 1);  // mid-slot change, not yet applied
    add(1, 5, 1, 1, 0, 0, 1);  // slot 1, period 5: 2 high / 3 low
    add(1, 5, 1, 1, 0, 0, 1);
    add(1, 5, 0, 1, 0, 0, 1);
    add(1, 5, 0, 1, 0, 0, 1);
    add(1, 5, 0, 1, 0, 0, 1);
    add(1, 5, 1, 2, 0, 0, 1);  // slot 2
    add(0, 5, 1, 2, 0, 0, 1);  // stop request mid-slot
    add(0, 5, 0, 2, 0, 0, 1);
    add(0, 5, 0, 2, 0, 0, 1);
    add(0, 5, 0, 2, 0, 0, 1);  // slot completes in full
    add(0, 5, 0, 0, 0, 0, 0);  // idle
    add(0, 5, 0, 0, 0, 0, 0);
    add(1, 8, 1, 0, 1, 0, 1);  // restart at slot 0 with rev
    add(0, 8, 1, 0, 0, 0, 1);
    add(0, 8, 1, 0, 0, 0, 1);
    add(0, 8, 1, 0, 0, 0, 1);
    add(0, 8, 0, 0, 0, 0, 1);
    add(0, 8, 0, 0, 0, 0, 1);
    add(0, 8, 0, 0, 0, 0, 1);
    add(0, 8, 0, 0, 0, 0, 1);
    add(1, 8, 1, 1, 0, 0, 1);  // ena back exactly at the boundary: keep running

    foreach (tbl[i]) begin
      ena    = tbl[i].ena;
      period = tbl[i].per;
      tick();
      chk($sformatf("vec%0d", i), outs(),
          pk(tbl[i].t, tbl[i].num, tbl[i].rev, tbl[i].gap, tbl[i].bsy));
    end

    // Full wheel at period 8 with a simple edge-interval receiver alongside.
    ena = 1'b0;
    restart();
    ena    = 1'b1;
    period = 24'd8;
    s = 0; c = 0; last_rev = -1; last_rise = -1; last_iv = 0;
    rx_cnt = 0; gaps = 0; revs = 0; prev_t = 1'b0;
    for (int k = 0; k < 1906; k++) begin
      tick();
      chk($sformatf("wheel_k%0d", k), outs(),
          pk((s < 58) && (c < 4), 8'(s), (s == 0) && (c == 0), s >= 58, 1'b1));
      if (rev_pulse) begin
        revs++;
        if (last_rev >= 0) chk("rev_spacing", k - last_rev, 480);
        last_rev = k;
      end
      if (tooth_out && !prev_t) begin
        if (last_rise >= 0 && last_iv > 0 && (k - last_rise) > 2 * last_iv) begin
          gaps++;
          chk("rx_gap_tooth_num", 32'(tooth_num), 0);
          chk("rx_teeth_per_rev", rx_cnt, 57);
          rx_cnt = 0;
        end else if (last_rise >= 0) begin
          last_iv = k - last_rise;
          rx_cnt++;
          chk("rx_tooth_align", 32'(tooth_num), rx_cnt);
        end
        last_rise = k;
      end
      prev_t = tooth_out;
      c++;
      if (c == 8) begin
        c = 0;
        s = (s == 59) ? 0 : s + 1;
      end
    end
    chk("rx_gap_count", gaps, 3);
    chk("rev_count", revs, 4);

    // Stop requested in slot 58 cycle 1: gap slot finishes silent, then idle.
    ena = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("gap_stop_run", outs(), pk(1'b0, 8'd58, 1'b0, 1'b1, 1'b1));
    end
    tick();
    chk("gap_stop_idle", outs(), pk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0));

    // Period 8 -> 12 during slot 5 cycle 3.
    restart();
    ena    = 1'b1;
    period = 24'd8;
    for (int k = 0; k < 44; k++) tick();
    chk("pre_change_slot5", outs(), pk(1'b1, 8'd5, 1'b0, 1'b0, 1'b1));
    period = 24'd12;
    for (int k = 44; k <= 60; k++) begin
      tick();
      if (k < 48)      exp = pk(1'b0, 8'd5, 1'b0, 1'b0, 1'b1);
      else if (k < 54) exp = pk(1'b1, 8'd6, 1'b0, 1'b0, 1'b1);
      else if (k < 60) exp = pk(1'b0, 8'd6, 1'b0, 1'b0, 1'b1);
      else             exp = pk(1'b1, 8'd7, 1'b0, 1'b0, 1'b1);
      chk($sformatf("period_change_k%0d", k), outs(), exp);
    end

    // Asynchronous reset in the high phase of slot 2.
    restart();
    ena    = 1'b1;
    period = 24'd8;
    for (int k = 0; k < 18; k++) tick();
    chk("pre_reset_high", outs(), pk(1'b1, 8'd2, 1'b0, 1'b0, 1'b1));
    #3 rst = 1'b0;
    #1;
    chk("async_reset", outs(), pk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0));
    #1 rst = 1'b1;
    tick();
    chk("restart_after_reset", outs(), pk(1'b1, 8'd0, 1'b1, 1'b0, 1'b1));
    tick();
    chk("restart_cycle1", outs(), pk(1'b1, 8'd0, 1'b0, 1'b0, 1'b1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
